// File: rtl/op_acc.sv
// ---------------------------------------------------------------------------
// op_acc
//   Streaming frame accumulator placed after the op_add adder stage. Sums LEN
//   accepted samples into an ACC_W-bit accumulator (signed or unsigned,
//   saturating or wrapping). Each completed frame is presented on a registered
//   valid/ready output together with sticky overflow/underflow flags that
//   cover every sample of the frame.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream sample present
//   in_ready   block can accept a sample (high while accumulating)
//   in_data    N-bit sample (adder result)
//   in_ov      upstream positive-overflow flag for this sample
//   in_uv      upstream underflow flag for this sample
//   out_valid  completed frame available
//   out_ready  downstream accepts the frame
//   out_data   ACC_W-bit frame sum
//   out_ov     sticky positive overflow for the frame
//   out_uv     sticky underflow for the frame
// ---------------------------------------------------------------------------
module op_acc #(
  parameter int N        = 16,
  parameter int ACC_W    = 24,
  parameter int LEN      = 8,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_ov,
  input  logic             in_uv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ov,
  output logic             out_uv
);

  localparam int CNT_W = $clog2(LEN + 1);

  localparam logic [ACC_W-1:0] ACC_MAX = (SIGNED != 0) ?
                                         {1'b0, {(ACC_W-1){1'b1}}} :
                                         {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ov_stk;
  logic             uv_stk;

  logic [ACC_W:0]   smp_ext;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   sum;
  logic             pos_ovf;
  logic             neg_ovf;
  logic [ACC_W-1:0] acc_next;
  logic             ov_next;
  logic             uv_next;
  logic             accept;
  logic             last;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == LAST_CNT);

  // The sum is formed one bit wider than the accumulator so that leaving the
  // representable range is visible in the extra top bit.
  always_comb begin
    smp_ext  = '0;
    acc_ext  = '0;
    sum      = '0;
    pos_ovf  = 1'b0;
    neg_ovf  = 1'b0;
    acc_next = '0;

    if (SIGNED != 0) begin
      smp_ext = {{(ACC_W+1-N){in_data[N-1]}}, in_data};
      acc_ext = {acc[ACC_W-1], acc};
    end else begin
      smp_ext = {{(ACC_W+1-N){1'b0}}, in_data};
      acc_ext = {1'b0, acc};
    end

    sum = acc_ext + smp_ext;

    // Signed: top two bits disagree on overflow, the guard bit gives the
    // direction. Unsigned: a carry into the guard bit is the only failure.
    if (SIGNED != 0) begin
      pos_ovf = (sum[ACC_W] != sum[ACC_W-1]) && !sum[ACC_W];
      neg_ovf = (sum[ACC_W] != sum[ACC_W-1]) &&  sum[ACC_W];
    end else begin
      pos_ovf = sum[ACC_W];
      neg_ovf = 1'b0;
    end

    if ((SATURATE != 0) && pos_ovf) begin
      acc_next = ACC_MAX;
    end else if ((SATURATE != 0) && neg_ovf) begin
      acc_next = ACC_MIN;
    end else begin
      acc_next = sum[ACC_W-1:0];
    end
  end

  assign ov_next = ov_stk | in_ov | pos_ovf;
  assign uv_next = uv_stk | in_uv | neg_ovf;

  // Frame state machine. The completing accept moves the next-state values
  // straight into the output registers and clears the running frame, so the
  // accumulator is already zeroed when the block returns to ACCUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ov_stk    <= 1'b0;
      uv_stk    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ov    <= 1'b0;
      out_uv    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              out_data  <= acc_next;
              out_ov    <= ov_next;
              out_uv    <= uv_next;
              out_valid <= 1'b1;
              state     <= HOLD;
              acc       <= '0;
              cnt       <= '0;
              ov_stk    <= 1'b0;
              uv_stk    <= 1'b0;
            end else begin
              acc    <= acc_next;
              cnt    <= cnt + 1'b1;
              ov_stk <= ov_next;
              uv_stk <= uv_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_acc.sv
// ---------------------------------------------------------------------------
// tb_op_acc
//   Directed bench for op_acc. Five instances cover the parameter sets of
//   interest; a select value routes the shared stimulus to one of them and
//   muxes its outputs back. Expected frames come from an integer model of the
//   accumulator and are queued when the completing sample is accepted; a
//   monitor pops and compares them on each output handshake.
// ---------------------------------------------------------------------------
module tb_op_acc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ov;
  logic        in_uv;
  logic        out_ready;
  int          sel;

  logic        rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
  logic        vld_a, vld_b, vld_c, vld_d, vld_e;
  logic        ov_a, ov_b, ov_c, ov_d, ov_e;
  logic        uv_a, uv_b, uv_c, uv_d, uv_e;
  logic [23:0] dat_a;
  logic [17:0] dat_b;
  logic [17:0] dat_c;
  logic [15:0] dat_d;
  logic [23:0] dat_e;

  logic        obs_ready;
  logic        obs_valid;
  logic [23:0] obs_data;
  logic        obs_ov;
  logic        obs_uv;

  typedef struct {
    logic [23:0] data;
    logic        ov;
    logic        uv;
  } exp_t;

  exp_t sbq[$];

  int n_vec;
  int n_err;

  int     m_w;
  bit     m_signed;
  bit     m_sat;
  int     m_len;
  longint m_acc;
  int     m_cnt;
  bit     m_ov;
  bit     m_uv;

  op_acc #(.N(16), .ACC_W(24), .LEN(8), .SIGNED(1), .SATURATE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 0)), .in_ready(rdy_a),
    .in_data(in_data), .in_ov(in_ov), .in_uv(in_uv), .out_valid(vld_a),
    .out_ready(out_ready), .out_data(dat_a), .out_ov(ov_a), .out_uv(uv_a)
  );

  op_acc #(.N(16), .ACC_W(18), .LEN(8), .SIGNED(1), .SATURATE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 1)), .in_ready(rdy_b),
    .in_data(in_data), .in_ov(in_ov), .in_uv(in_uv), .out_valid(vld_b),
    .out_ready(out_ready), .out_data(dat_b), .out_ov(ov_b), .out_uv(uv_b)
  );

  op_acc #(.N(16), .ACC_W(18), .LEN(8), .SIGNED(1), .SATURATE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2)), .in_ready(rdy_c),
    .in_data(in_data), .in_ov(in_ov), .in_uv(in_uv), .out_valid(vld_c),
    .out_ready(out_ready), .out_data(dat_c), .out_ov(ov_c), .out_uv(uv_c)
  );

  op_acc #(.N(16), .ACC_W(16), .LEN(2), .SIGNED(0), .SATURATE(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 3)), .in_ready(rdy_d),
    .in_data(in_data), .in_ov(in_ov), .in_uv(in_uv), .out_valid(vld_d),
    .out_ready(out_ready), .out_data(dat_d), .out_ov(ov_d), .out_uv(uv_d)
  );

  op_acc #(.N(16), .ACC_W(24), .LEN(1), .SIGNED(1), .SATURATE(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 4)), .in_ready(rdy_e),
    .in_data(in_data), .in_ov(in_ov), .in_uv(in_uv), .out_valid(vld_e),
    .out_ready(out_ready), .out_data(dat_e), .out_ov(ov_e), .out_uv(uv_e)
  );

  // Route the selected instance's outputs onto one set of observed signals.
  always_comb begin
    obs_ready = rdy_a;
    obs_valid = vld_a;
    obs_data  = dat_a;
    obs_ov    = ov_a;
    obs_uv    = uv_a;
    case (sel)
      1: begin
        obs_ready = rdy_b; obs_valid = vld_b; obs_data = {6'b0, dat_b};
        obs_ov    = ov_b;  obs_uv    = uv_b;
      end
      2: begin
        obs_ready = rdy_c; obs_valid = vld_c; obs_data = {6'b0, dat_c};
        obs_ov    = ov_c;  obs_uv    = uv_c;
      end
      3: begin
        obs_ready = rdy_d; obs_valid = vld_d; obs_data = {8'b0, dat_d};
        obs_ov    = ov_d;  obs_uv    = uv_d;
      end
      4: begin
        obs_ready = rdy_e; obs_valid = vld_e; obs_data = dat_e;
        obs_ov    = ov_e;  obs_uv    = uv_e;
      end
      default: begin
      end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence stalls somewhere unexpected.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic selectDut(input int k, input int w, input bit sgn, input bit sat, input int len);
    sel      = k;
    m_w      = w;
    m_signed = sgn;
    m_sat    = sat;
    m_len    = len;
    m_acc    = 0;
    m_cnt    = 0;
    m_ov     = 1'b0;
    m_uv     = 1'b0;
  endtask

  task automatic modelClear();
    m_acc = 0;
    m_cnt = 0;
    m_ov  = 1'b0;
    m_uv  = 1'b0;
  endtask

  // Integer reference: add, compare against the numeric range, then clamp or
  // wrap by a whole modulus.
  task automatic modelAccept(input logic [15:0] d, input bit ov, input bit uv);
    longint s;
    longint modv;
    longint hi;
    longint lo;
    longint sum;
    exp_t   e;
    modv = longint'(1) << m_w;
    if (m_signed) begin
      s  = longint'($signed(d));
      hi = modv / 2 - 1;
      lo = -(modv / 2);
    end else begin
      s  = longint'(d);
      hi = modv - 1;
      lo = 0;
    end
    sum = m_acc + s;
    if (sum > hi) begin
      m_ov = 1'b1;
      sum  = m_sat ? hi : sum - modv;
    end else if (sum < lo) begin
      m_uv = 1'b1;
      sum  = m_sat ? lo : sum + modv;
    end
    m_ov  = m_ov | ov;
    m_uv  = m_uv | uv;
    m_acc = sum;
    m_cnt++;
    if (m_cnt == m_len) begin
      e.data = 24'(sum & (modv - 1));
      e.ov   = m_ov;
      e.uv   = m_uv;
      sbq.push_back(e);
      modelClear();
    end
  endtask

  // Present one sample, wait (bounded) for in_ready, and return #1 after the
  // accepting edge with in_valid still high.
  task automatic applyStimulus(input logic [15:0] d, input bit ov, input bit uv);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_ov    = ov;
    in_uv    = uv;
    t = 0;
    while (!obs_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkOutput("in_ready_wait", {31'b0, obs_ready}, 32'd1);
    @(posedge clk);
    modelAccept(d, ov, uv);
    #1;
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard side: every output handshake must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n && obs_valid && out_ready) begin
      exp_t e;
      checkOutput("sb_expected_frame", {31'b0, (sbq.size() != 0)}, 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checkOutput("frame_data", {8'b0, obs_data}, {8'b0, e.data});
        checkOutput("frame_ov", {31'b0, obs_ov}, {31'b0, e.ov});
        checkOutput("frame_uv", {31'b0, obs_uv}, {31'b0, e.uv});
      end
    end
  end

  logic [23:0] held;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ov     = 1'b0;
    in_uv     = 1'b0;
    out_ready = 1'b1;
    selectDut(0, 24, 1'b1, 1'b1, 8);

    // Reset values, observed while reset is still asserted.
    #12;
    checkOutput("rst_in_ready", {31'b0, obs_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, obs_valid}, 32'd0);
    checkOutput("rst_out_data", {8'b0, obs_data}, 32'd0);
    checkOutput("rst_out_flags", {30'b0, obs_ov, obs_uv}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(2);
    checkOutput("post_rst_valid", {31'b0, obs_valid}, 32'd0);

    // Basic frame 1..8 with valid held high; latency and one-cycle bubble.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(16'(i), 1'b0, 1'b0);
      if (i == 7) checkOutput("t1_valid_early", {31'b0, obs_valid}, 32'd0);
    end
    checkOutput("t1_valid_latency", {31'b0, obs_valid}, 32'd1);
    checkOutput("t1_ready_low", {31'b0, obs_ready}, 32'd0);
    idleCycles(1);
    checkOutput("t1_valid_cleared", {31'b0, obs_valid}, 32'd0);
    checkOutput("t1_ready_back", {31'b0, obs_ready}, 32'd1);
    checkOutput("t1_data_kept", {8'b0, obs_data}, 32'd36);

    // Upstream overflow flag on sample 3 only, then a clean frame.
    for (int i = 1; i <= 8; i++) applyStimulus(16'd0, (i == 3), 1'b0);
    idleCycles(2);
    for (int i = 1; i <= 8; i++) applyStimulus(16'd5, 1'b0, 1'b0);
    idleCycles(2);

    // Mixed-sign samples with an upstream underflow flag.
    for (int i = 1; i <= 8; i++) applyStimulus((i % 2 == 0) ? 16'hFF00 : 16'd300, 1'b0, (i == 8));
    idleCycles(2);

    // Backpressure for five cycles after completion.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) applyStimulus(16'(100 + i), 1'b0, 1'b0);
    in_valid = 1'b0;
    held = obs_data;
    checkOutput("bp_data_value", {8'b0, held}, 32'd836);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid_stable", {31'b0, obs_valid}, 32'd1);
      checkOutput("bp_data_stable", {8'b0, obs_data}, {8'b0, held});
      checkOutput("bp_ready_low", {31'b0, obs_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idleCycles(1);
    checkOutput("bp_released", {31'b0, obs_valid}, 32'd0);
    for (int i = 1; i <= 8; i++) applyStimulus(16'd2, 1'b0, 1'b0);
    idleCycles(2);

    // Reset mid-frame discards the partial sum.
    for (int i = 0; i < 4; i++) applyStimulus(16'd10, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_ready", {31'b0, obs_ready}, 32'd1);
    modelClear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(16'd1, 1'b0, 1'b0);
    idleCycles(2);

    // Reset during HOLD drops the pending frame immediately.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(16'd7, 1'b0, 1'b0);
    in_valid = 1'b0;
    checkOutput("hold_valid", {31'b0, obs_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("hold_rst_valid", {31'b0, obs_valid}, 32'd0);
    sbq.delete();
    modelClear();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idleCycles(2);
    checkOutput("hold_rst_no_frame", {31'b0, obs_valid}, 32'd0);

    // 18-bit saturating: positive then negative rail.
    selectDut(1, 18, 1'b1, 1'b1, 8);
    for (int i = 0; i < 8; i++) applyStimulus(16'h7FFF, 1'b0, 1'b0);
    idleCycles(2);
    for (int i = 0; i < 8; i++) applyStimulus(16'h8000, 1'b0, 1'b0);
    idleCycles(2);
    // Saturation does not freeze the sum: come back off the rail.
    for (int i = 0; i < 8; i++) applyStimulus((i < 6) ? 16'h7FFF : 16'h8000, 1'b0, 1'b0);
    idleCycles(2);

    // 18-bit wrapping.
    selectDut(2, 18, 1'b1, 1'b0, 8);
    for (int i = 0; i < 8; i++) applyStimulus(16'h7FFF, 1'b0, 1'b0);
    idleCycles(2);

    // Unsigned 16-bit, LEN=2.
    selectDut(3, 16, 1'b0, 1'b1, 2);
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'h0002, 1'b0, 1'b0);
    idleCycles(2);
    applyStimulus(16'h1234, 1'b0, 1'b0);
    applyStimulus(16'h0001, 1'b0, 1'b0);
    idleCycles(2);

    // LEN=1 with random gaps: one frame per accept.
    selectDut(4, 24, 1'b1, 1'b1, 1);
    for (int i = 0; i < 8; i++) begin
      idleCycles($urandom_range(0, 3));
      applyStimulus(16'($urandom_range(0, 65535)), 1'b0, 1'b0);
    end
    idleCycles(4);

    checkOutput("sb_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
